// File: rtl/instr_enc_pkg.sv
// Shared definitions for the RV32I instruction encoder: opcode values,
// instruction format enumeration, the canonical NOP word and the
// opcode-to-format decode helper.
package instr_enc_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_R      = 7'b0110011;

    // addi x0,x0,0 is emitted in place of any word whose opcode is unknown
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_ILL
    } fmt_e;

    function automatic fmt_e decode_fmt(input logic [6:0] op);
        fmt_e f;
        case (op)
            OP_IMM, OP_LOAD, OP_JALR: f = FMT_I;
            OP_STORE:                 f = FMT_S;
            OP_BRANCH:                f = FMT_B;
            OP_LUI, OP_AUIPC:         f = FMT_U;
            OP_JAL:                   f = FMT_J;
            OP_R:                     f = FMT_R;
            default:                  f = FMT_ILL;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Combinational core of the encoder: decodes the format from the opcode,
// scatters the immediate and register fields into the instruction word and
// raises the error flag.
// Build option: defining INSTR_ENC_RANGE_CHECK_EN also flags immediates
// that do not fit the selected format (the word is still packed from the
// truncated bits). Without it only illegal opcodes are flagged.
module imm_pack
    import instr_enc_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        err
);

    fmt_e fmt;

    // Pack fields according to the decoded format and compute the error flag
    always_comb begin
        fmt   = decode_fmt(opcode);
        instr = NOP_INSTR;
        err   = 1'b0;
        case (fmt)
            FMT_I: instr = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: instr = {imm[12], imm[10:5], rs2, rs1, funct3,
                            imm[4:1], imm[11], opcode};
            FMT_U: instr = {imm[31:12], rd, opcode};
            FMT_J: instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            FMT_R: instr = {funct7, rs2, rs1, funct3, rd, opcode};
            default: begin
                instr = NOP_INSTR;
                err   = 1'b1;
            end
        endcase
`ifdef INSTR_ENC_RANGE_CHECK_EN
        case (fmt)
            FMT_I, FMT_S: err = (imm[31:11] != {21{imm[11]}});
            FMT_B:        err = (imm[31:12] != {20{imm[12]}}) || imm[0];
            FMT_J:        err = (imm[31:20] != {12{imm[20]}}) || imm[0];
            FMT_U:        err = (imm[11:0] != 12'h000);
            FMT_R:        err = 1'b0;
            default:      err = 1'b1;
        endcase
`endif
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: a two-stage valid/ready pipeline. Stage 1
// captures the raw field set, stage 2 holds the packed word together with
// its error flag, and a wrapping counter stamps each delivered word with
// its instruction-memory word address.
// Build option: INSTR_ENC_RANGE_CHECK_EN enables immediate range checking
// inside imm_pack.
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err
);

    localparam logic [ADDR_W-1:0] ADDR_RST = ADDR_W'(BASE_ADDR);

    logic        s1_valid;
    logic [6:0]  s1_opcode;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [2:0]  s1_funct3;
    logic [6:0]  s1_funct7;
    logic [31:0] s1_imm;

    logic        s1_load;
    logic        s2_load;
    logic [31:0] pack_instr;
    logic        pack_err;

    // Stage 1 may take a new request whenever it is empty or will drain this cycle
    assign in_ready = !s1_valid || !out_valid || out_ready;
    assign s1_load  = in_valid && in_ready;
    assign s2_load  = s1_valid && (!out_valid || out_ready);

    imm_pack u_imm_pack (
        .opcode (s1_opcode),
        .rd     (s1_rd),
        .rs1    (s1_rs1),
        .rs2    (s1_rs2),
        .funct3 (s1_funct3),
        .funct7 (s1_funct7),
        .imm    (s1_imm),
        .instr  (pack_instr),
        .err    (pack_err)
    );

    // Stage 1 occupancy: set on accept, cleared when the word moves to stage 2
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 1 field capture; contents are only meaningful while s1_valid is set
    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_opcode <= opcode;
            s1_rd     <= rd;
            s1_rs1    <= rs1;
            s1_rs2    <= rs2;
            s1_funct3 <= funct3;
            s1_funct7 <= funct7;
            s1_imm    <= imm;
        end
    end

    // Output register: reload from stage 1 when free, hold while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_instr <= 32'h0;
            out_err   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            out_instr <= pack_instr;
            out_err   <= pack_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Word address advances once per delivered word and wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            out_addr <= ADDR_RST;
        end else if (out_valid && out_ready) begin
            out_addr <= out_addr + 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder. Directed field sets are driven by
// applyStimulus, which pushes the hand-computed word into a scoreboard on
// acceptance; an independent monitor pops and compares every delivered word
// together with its expected address.
module tb_instr_encoder;

    localparam int ADDR_W = 2;

`ifdef INSTR_ENC_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } expT;

    logic              clk = 1'b0;
    logic              reset;
    logic              inValid;
    logic              inReady;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm;
    logic              outValid;
    logic              outReady;
    logic [31:0]       outInstr;
    logic [ADDR_W-1:0] outAddr;
    logic              outErr;

    expT               sb[$];
    int                popCycles[$];
    logic [ADDR_W-1:0] expAddr = '0;
    int                total = 0;
    int                bad = 0;
    int                cyc = 0;
    int                acceptCount = 0;
    int                lastAccept = 0;

    bit                stallSeen = 1'b0;
    logic [31:0]       heldInstr;
    logic [ADDR_W-1:0] heldAddr;
    logic              heldErr;

    instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .imm       (imm),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_instr (outInstr),
        .out_addr  (outAddr),
        .out_err   (outErr)
    );

    // Free-running clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one field set and wait (bounded) until the encoder takes it
    task automatic applyStimulus(input logic [6:0] op, input logic [4:0] d,
                                 input logic [4:0] s1, input logic [4:0] s2,
                                 input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] im, input logic [31:0] expInstr,
                                 input logic expErr);
        bit done = 1'b0;
        int waits = 0;
        opcode = op; rd = d; rs1 = s1; rs2 = s2;
        funct3 = f3; funct7 = f7; imm = im;
        inValid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (inReady) begin
                sb.push_back('{instr: expInstr, err: expErr});
                acceptCount++;
                lastAccept = cyc;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            waits++;
            if (!done && waits > 200) begin
                total++;
                bad++;
                $display("[TB] FAIL accept_timeout: in_ready stayed %b expected 1", inReady);
                done = 1'b1;
            end
        end
        inValid = 1'b0;
    endtask

    // Wait (bounded) until every expected word has been delivered
    task automatic drain();
        int waits = 0;
        while (sb.size() != 0 && waits < 100) begin
            @(posedge clk);
            #1;
            waits++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain_timeout: pending=%0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Synchronous reset pulse, flushing the scoreboard and checking reset state
    task automatic doReset();
        reset = 1'b1;
        inValid = 1'b0;
        sb.delete();
        popCycles.delete();
        expAddr = '0;
        @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(outValid), 32'd0);
        checkOutput("rst_out_instr", outInstr, 32'h0);
        checkOutput("rst_out_err", 32'(outErr), 32'd0);
        checkOutput("rst_out_addr", 32'(outAddr), 32'd0);
        checkOutput("rst_in_ready", 32'(inReady), 32'd1);
        reset = 1'b0;
    endtask

    // Monitor: compare each delivered word and check stability during stalls
    always @(negedge clk) begin
        if (reset) begin
            stallSeen = 1'b0;
        end else begin
            if (stallSeen) begin
                checkOutput("hold_valid", 32'(outValid), 32'd1);
                checkOutput("hold_instr", outInstr, heldInstr);
                checkOutput("hold_addr", 32'(outAddr), 32'(heldAddr));
                checkOutput("hold_err", 32'(outErr), 32'(heldErr));
            end
            if (outValid && outReady) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_word: got %h expected none", outInstr);
                end else begin
                    expT e;
                    e = sb.pop_front();
                    checkOutput("word_instr", outInstr, e.instr);
                    checkOutput("word_err", 32'(outErr), 32'(e.err));
                    checkOutput("word_addr", 32'(outAddr), 32'(expAddr));
                    expAddr = expAddr + 1'b1;
                    popCycles.push_back(cyc);
                end
            end
            stallSeen = outValid && !outReady;
            heldInstr = outInstr;
            heldAddr  = outAddr;
            heldErr   = outErr;
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: cycles=%0d expected completion", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; inValid = 1'b0; outReady = 1'b1;
        opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
        funct3 = '0; funct7 = '0; imm = '0;
        @(posedge clk);
        #1;
        doReset();

        // addi x1,x0,5 with two-cycle latency
        $display("[TB] addi latency");
        applyStimulus(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0);
        drain();
        checkOutput("addi_latency", 32'(popCycles.size() > 0 ? popCycles[0] - lastAccept : -1), 32'd2);

        // sw then beq back-to-back on consecutive cycles
        $display("[TB] store/branch back-to-back");
        doReset();
        applyStimulus(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020A423, 1'b0);
        applyStimulus(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0);
        drain();
        checkOutput("b2b_gap", 32'(popCycles.size() > 1 ? popCycles[1] - popCycles[0] : -1), 32'd1);

        // Remaining formats and the illegal opcode; addresses wrap at 4
        $display("[TB] formats");
        applyStimulus(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h001000EF, 1'b0);
        applyStimulus(7'b1111111, 5'd3, 5'd4, 5'd5, 3'd1, 7'd9, 32'h12345678, 32'h00000013, 1'b1);
        applyStimulus(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0);
        applyStimulus(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 32'h002081B3, 1'b0);
        applyStimulus(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0, 32'h402081B3, 1'b0);
        applyStimulus(7'b0000011, 5'd6, 5'd2, 5'd0, 3'd2, 7'd0, 32'hFFFFFFFC, 32'hFFC12303, 1'b0);
        applyStimulus(7'b1100111, 5'd0, 5'd1, 5'd0, 3'd0, 7'd0, 32'd0, 32'h00008067, 1'b0);
        applyStimulus(7'b0010111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001000, 32'h00001097, 1'b0);
        drain();

        // Immediate range boundaries
        $display("[TB] immediate ranges");
        applyStimulus(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, 32'h00000093, RC);
        applyStimulus(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h00000163, RC);
        applyStimulus(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h80000093, RC);
        applyStimulus(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047, 32'h7FF00093, 1'b0);
        applyStimulus(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFFF800, 32'h8020A023, 1'b0);
        applyStimulus(7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF00000, 32'h8000006F, 1'b0);
        applyStimulus(7'b0110111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000001, 32'h000000B7, RC);
        drain();

        // Back-pressure: three requests against a stalled consumer
        $display("[TB] stall");
        doReset();
        outReady = 1'b0;
        acceptCount = 0;
        fork
            begin
                applyStimulus(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 32'h002081B3, 1'b0);
                applyStimulus(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0, 32'h402081B3, 1'b0);
                applyStimulus(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                @(negedge clk);
                checkOutput("stall_accepts", 32'(acceptCount), 32'd2);
                checkOutput("stall_in_ready", 32'(inReady), 32'd0);
                @(posedge clk);
                #1;
                outReady = 1'b1;
            end
        join
        drain();

        // Five words from reset exercise the 2-bit address wrap
        $display("[TB] address wrap");
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(i), 32'h00000093 | (32'(i) << 20), 1'b0);
        end
        drain();
        checkOutput("wrap_count", 32'(popCycles.size()), 32'd5);

        // Reset with both stages full discards everything
        $display("[TB] reset mid-stream");
        outReady = 1'b0;
        applyStimulus(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 32'h002081B3, 1'b0);
        applyStimulus(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0, 32'h402081B3, 1'b0);
        @(negedge clk);
        checkOutput("full_in_ready", 32'(inReady), 32'd0);
        @(posedge clk);
        #1;
        doReset();
        outReady = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("post_rst_valid", 32'(outValid), 32'd0);
        end
        @(posedge clk);
        #1;
        applyStimulus(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0);
        drain();
        checkOutput("post_rst_words", 32'(popCycles.size()), 32'd1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
